// File: rtl/snooper_pkg.sv
// Shared definitions for the dataval frame snooper.
//
// Contents:
//   snoopState_e  - FSM state encoding (IDLE, CAPTURE, DROP, COMMIT)
//   COUNT_EXTRA   - extra bits a word counter needs over the word address,
//                   so the counter can hold the full 2**ADDR_WIDTH count
//   STATS_WIDTH   - width of the optional frame statistics counters
//   countWidth()  - helper turning a word-address width into a counter width
package snooper_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DROP    = 2'd2,
        COMMIT  = 2'd3
    } snoopState_e;

    localparam int unsigned COUNT_EXTRA = 1;
    localparam int unsigned STATS_WIDTH = 32;

    function automatic int unsigned countWidth(input int unsigned addrWidth);
        return addrWidth + COUNT_EXTRA;
    endfunction

endpackage

// File: rtl/snooper_stats.sv
// Optional frame statistics for the dataval frame snooper.
// Only present when DATAVAL_SNOOPER_STATS_EN is defined.
//
// Ports:
//   clk             - rising-edge clock
//   rst_n           - asynchronous active-low reset
//   frameDone_i     - one-cycle pulse per committed frame
//   dropEntry_i     - one-cycle pulse per entry into the DROP state
//   framesOk_o      - wrapping count of committed frames
//   framesDropped_o - wrapping count of DROP entries
`ifdef DATAVAL_SNOOPER_STATS_EN
module snooper_stats
    import snooper_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frameDone_i,
    input  logic                   dropEntry_i,
    output logic [STATS_WIDTH-1:0] framesOk_o,
    output logic [STATS_WIDTH-1:0] framesDropped_o
);

    logic [STATS_WIDTH-1:0] framesOk_q;
    logic [STATS_WIDTH-1:0] framesDropped_q;

    // Free-running counters; they wrap silently at 2**STATS_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            framesOk_q      <= '0;
            framesDropped_q <= '0;
        end else begin
            if (frameDone_i) begin
                framesOk_q <= framesOk_q + STATS_WIDTH'(1);
            end
            if (dropEntry_i) begin
                framesDropped_q <= framesDropped_q + STATS_WIDTH'(1);
            end
        end
    end

    assign framesOk_o      = framesOk_q;
    assign framesDropped_o = framesDropped_q;

endmodule
`endif

// File: rtl/dataval_frame_snooper.sv
// Dataval frame snooper: watches a strobed data bus and copies each frame
// into a packet memory, starting at word address 0, reporting completion
// with a one-cycle done pulse plus word count and truncation flag.
//
// A frame is only captured if mem_ready is high on its first beat;
// otherwise the whole frame is discarded. Beats beyond MAX_WORDS are not
// written but still counted for the truncation flag.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   data, strobe    - snooped bus word and its valid
//   last            - strobed word is the final word of the frame
//   mem_ready       - memory can accept a new frame (sampled at frame start)
//   wr_addr/data/en - registered packet memory write port
//   done            - one-cycle pulse after the final write of a frame
//   word_count      - words written for the committed frame (held)
//   truncated       - committed frame exceeded MAX_WORDS (held)
//   frames_ok, frames_dropped - statistics, only with DATAVAL_SNOOPER_STATS_EN
//
// Configuration macro: DATAVAL_SNOOPER_STATS_EN
module dataval_frame_snooper
    import snooper_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 2 ** ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic                   strobe,
    input  logic                   last,
    input  logic                   mem_ready,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_en,
    output logic                   done,
    output logic [ADDR_WIDTH:0]    word_count,
    output logic                   truncated
`ifdef DATAVAL_SNOOPER_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] frames_ok,
    output logic [STATS_WIDTH-1:0] frames_dropped
`endif
);

    localparam int CNT_W = int'(countWidth(ADDR_WIDTH));
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    snoopState_e           state_q;
    logic                  wrEn_q;
    logic [ADDR_WIDTH-1:0] wrAddr_q;
    logic [DATA_WIDTH-1:0] wrData_q;
    logic                  done_q;
    logic [CNT_W-1:0]      wordCount_q;
    logic                  truncated_q;
    logic [CNT_W-1:0]      written_q;
    logic                  overflow_q;
    logic [CNT_W-1:0]      written_d;
    logic                  roomLeft;
`ifdef DATAVAL_SNOOPER_STATS_EN
    logic                  dropPulse_q;
`endif

    // written_q counts words already stored in the current frame, which is
    // also the address of the next word; it never exceeds MAX_WORDS, so the
    // address taken from its low bits cannot wrap.
    assign written_d = written_q + CNT_W'(1);
    assign roomLeft  = (written_q < MAX_CNT);

    // Frame FSM with all outputs registered. COMMIT behaves like IDLE for
    // new strobes so a frame can start in the same cycle the previous one
    // is being committed, with no lost beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
            done_q      <= 1'b0;
            wordCount_q <= '0;
            truncated_q <= 1'b0;
            written_q   <= '0;
            overflow_q  <= 1'b0;
`ifdef DATAVAL_SNOOPER_STATS_EN
            dropPulse_q <= 1'b0;
`endif
        end else begin
            wrEn_q <= 1'b0;
            done_q <= 1'b0;
`ifdef DATAVAL_SNOOPER_STATS_EN
            dropPulse_q <= 1'b0;
`endif
            case (state_q)
                IDLE, COMMIT: begin
                    // Report the frame whose last write is on the bus now.
                    if (state_q == COMMIT) begin
                        done_q      <= 1'b1;
                        wordCount_q <= written_q;
                        truncated_q <= overflow_q;
                    end
                    if (strobe) begin
                        if (mem_ready) begin
                            wrEn_q     <= 1'b1;
                            wrAddr_q   <= '0;
                            wrData_q   <= data;
                            written_q  <= CNT_W'(1);
                            overflow_q <= 1'b0;
                            state_q    <= last ? COMMIT : CAPTURE;
                        end else begin
                            state_q <= last ? IDLE : DROP;
`ifdef DATAVAL_SNOOPER_STATS_EN
                            dropPulse_q <= !last;
`endif
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CAPTURE: begin
                    if (strobe) begin
                        if (roomLeft) begin
                            wrEn_q    <= 1'b1;
                            wrAddr_q  <= written_q[ADDR_WIDTH-1:0];
                            wrData_q  <= data;
                            written_q <= written_d;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                        if (last) begin
                            state_q <= COMMIT;
                        end
                    end
                end
                DROP: begin
                    if (strobe && last) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr_en      = wrEn_q;
    assign wr_addr    = wrAddr_q;
    assign wr_data    = wrData_q;
    assign done       = done_q;
    assign word_count = wordCount_q;
    assign truncated  = truncated_q;

`ifdef DATAVAL_SNOOPER_STATS_EN
    snooper_stats uStats (
        .clk             (clk),
        .rst_n           (rst_n),
        .frameDone_i     (done_q),
        .dropEntry_i     (dropPulse_q),
        .framesOk_o      (frames_ok),
        .framesDropped_o (frames_dropped)
    );
`endif

endmodule

// File: tb/tb_dataval_frame_snooper.sv
// Scoreboard testbench for dataval_frame_snooper (ADDR_WIDTH=3, MAX_WORDS=4).
// Directed frames push their hand-computed writes and done reports into
// queues; a monitor pops and compares whenever the DUT presents an output.
module tb_dataval_frame_snooper;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int CW = AW + 1;
    localparam int MW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wrExp_t;

    typedef struct {
        logic [CW-1:0] count;
        logic          trunc;
        int            cyc;
    } doneExp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data = '0;
    logic          strobe = 1'b0;
    logic          last = 1'b0;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          done;
    logic [CW-1:0] word_count;
    logic          truncated;
`ifdef DATAVAL_SNOOPER_STATS_EN
    logic [31:0]   frames_ok;
    logic [31:0]   frames_dropped;
`endif

    int       cyc = 0;
    int       vectors = 0;
    int       miscompares = 0;
    bit       drainReq = 1'b0;
    bit       drainDone = 1'b0;
    wrExp_t   wrQ[$];
    doneExp_t doneQ[$];

    dataval_frame_snooper #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_WORDS  (MW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .strobe     (strobe),
        .last       (last),
        .mem_ready  (mem_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .done       (done),
        .word_count (word_count),
        .truncated  (truncated)
`ifdef DATAVAL_SNOOPER_STATS_EN
        ,
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped)
`endif
    );

    // Free-running clock and cycle stamp used to check output latency.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One comparison: bumps the vector count, reports and counts a miss.
    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Drives one frame and queues its expected writes and done report.
    // hole >= 0 inserts an unstrobed cycle with last=1 after that beat.
    task automatic applyStimulus(input int nBeats, input logic [DW-1:0] base,
                                 input logic readyFirst, input logic readyLater,
                                 input int expWrites, input bit expDone,
                                 input int expCount, input bit expTrunc,
                                 input int gap, input int hole);
        for (int i = 0; i < nBeats; i++) begin
            @(negedge clk);
            strobe    = 1'b1;
            data      = base + DW'(i);
            last      = (i == nBeats - 1);
            mem_ready = (i == 0) ? readyFirst : readyLater;
            if (i < expWrites) begin
                wrQ.push_back('{addr: AW'(i), data: base + DW'(i), cyc: cyc + 1});
            end
            if (last && expDone) begin
                doneQ.push_back('{count: CW'(expCount), trunc: expTrunc, cyc: cyc + 2});
            end
            if (i == hole && !last) begin
                @(negedge clk);
                strobe = 1'b0;
                last   = 1'b1;
                data   = 32'hDEAD_BEEF;
            end
        end
        if (gap > 0) begin
            @(negedge clk);
            strobe    = 1'b0;
            last      = 1'b0;
            mem_ready = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    // Monitor: reset values while rst_n is low, scoreboard pops otherwise.
    always begin : monitor
        wrExp_t   we;
        doneExp_t de;
        @(negedge clk or negedge rst_n);
        #1;
        if (!rst_n) begin
            checkOutput("rst_wr_en", 64'(wr_en), 64'd0);
            checkOutput("rst_wr_addr", 64'(wr_addr), 64'd0);
            checkOutput("rst_wr_data", 64'(wr_data), 64'd0);
            checkOutput("rst_done", 64'(done), 64'd0);
            checkOutput("rst_word_count", 64'(word_count), 64'd0);
            checkOutput("rst_truncated", 64'(truncated), 64'd0);
`ifdef DATAVAL_SNOOPER_STATS_EN
            checkOutput("rst_frames_ok", 64'(frames_ok), 64'd0);
            checkOutput("rst_frames_dropped", 64'(frames_dropped), 64'd0);
`endif
        end else begin
            if (wr_en) begin
                if (wrQ.size() == 0) begin
                    checkOutput("wr_unexpected_addr", 64'(wr_addr), 64'hFFFF);
                end else begin
                    we = wrQ.pop_front();
                    checkOutput("wr_addr", 64'(wr_addr), 64'(we.addr));
                    checkOutput("wr_data", 64'(wr_data), 64'(we.data));
                    checkOutput("wr_cycle", 64'(cyc), 64'(we.cyc));
                end
            end
            if (done) begin
                if (doneQ.size() == 0) begin
                    checkOutput("done_unexpected_count", 64'(word_count), 64'hFFFF);
                end else begin
                    de = doneQ.pop_front();
                    checkOutput("word_count", 64'(word_count), 64'(de.count));
                    checkOutput("truncated", 64'(truncated), 64'(de.trunc));
                    checkOutput("done_cycle", 64'(cyc), 64'(de.cyc));
                end
            end
        end
        if (drainReq && !drainDone) begin
            checkOutput("writes_outstanding", 64'(wrQ.size()), 64'd0);
            checkOutput("dones_outstanding", 64'(doneQ.size()), 64'd0);
            drainDone = 1'b1;
        end
    end

    // Directed frame sequence.
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Four-beat frame; mem_ready dropping after the start is ignored.
        applyStimulus(4, 32'hA0, 1'b1, 1'b0, 4, 1'b1, 4, 1'b0, 2, -1);

        // Frame refused by mem_ready, then an accepted two-beat frame.
        applyStimulus(3, 32'hB0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1, -1);
        applyStimulus(2, 32'hC0, 1'b1, 1'b1, 2, 1'b1, 2, 1'b0, 2, -1);

        // Six beats against a four-word limit.
        applyStimulus(6, 32'hD0, 1'b1, 1'b1, 4, 1'b1, 4, 1'b1, 2, -1);

        // Single-beat frame.
        applyStimulus(1, 32'hE0, 1'b1, 1'b1, 1, 1'b1, 1, 1'b0, 2, -1);

        // Back-to-back frames, second starting in the COMMIT cycle.
        applyStimulus(3, 32'h10, 1'b1, 1'b1, 3, 1'b1, 3, 1'b0, 0, -1);
        applyStimulus(2, 32'h20, 1'b1, 1'b1, 2, 1'b1, 2, 1'b0, 2, -1);

        // Unstrobed last inside a frame must not end it.
        applyStimulus(3, 32'h30, 1'b1, 1'b1, 3, 1'b1, 3, 1'b0, 2, 0);

        // Committed frame immediately followed by a refused frame.
        applyStimulus(2, 32'h40, 1'b1, 1'b1, 2, 1'b1, 2, 1'b0, 0, -1);
        applyStimulus(2, 32'h50, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 2, -1);

        // Reset after beat two of a five-beat frame: no done may follow.
        @(negedge clk);
        strobe = 1'b1; data = 32'h70; last = 1'b0; mem_ready = 1'b1;
        wrQ.push_back('{addr: AW'(0), data: 32'h70, cyc: cyc + 1});
        @(negedge clk);
        data = 32'h71;
        wrQ.push_back('{addr: AW'(1), data: 32'h71, cyc: cyc + 1});
        @(negedge clk);
        strobe = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First frame after reset starts at address 0.
        applyStimulus(2, 32'h60, 1'b1, 1'b1, 2, 1'b1, 2, 1'b0, 2, -1);

        repeat (4) @(negedge clk);
        drainReq = 1'b1;
        repeat (3) @(negedge clk);
        if (!drainDone) begin
            $display("[TB] FAIL drain: monitor did not complete final check");
            $fatal(1, "[TB] monitor stalled");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
